// File: rtl/corevx_pkg.sv
// Shared constants and types for the corevx writeback slice.
// Holds the load funct3 encodings, data width and register address width.
package corevx_pkg;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = $clog2(NREGS);

   localparam logic [2:0] LOAD_LB  = 3'd0;
   localparam logic [2:0] LOAD_LH  = 3'd1;
   localparam logic [2:0] LOAD_LW  = 3'd2;
   localparam logic [2:0] LOAD_LBU = 3'd4;
   localparam logic [2:0] LOAD_LHU = 3'd5;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   xdata_t;

endpackage

// File: rtl/corevx_writeback_if.sv
// Bundle between decode/ALU/LSU and the writeback stage.
// The master drives issue, ALU and load inputs; the slave (writeback) drives the write port and hazard status.
interface corevx_writeback_if;
   import corevx_pkg::*;

   logic      iss_valid;
   logic      iss_long;
   reg_addr_t iss_rd_addr;
   reg_addr_t rs1_addr;
   reg_addr_t rs2_addr;
   logic      rs1_busy;
   logic      rs2_busy;

   logic      alu_valid;
   reg_addr_t alu_rd_addr;
   xdata_t    alu_wdata;

   logic      lsu_valid;
   logic      lsu_ready;
   reg_addr_t lsu_rd_addr;
   xdata_t    lsu_rdata;
   logic [2:0] lsu_funct3;
   logic [1:0] lsu_addr_lo;

   reg_addr_t rd_addr;
   xdata_t    rd_wdata;
   logic      rd_write;
   logic      err_waw;
   logic      err_misalign;

   modport master (
      output iss_valid, iss_long, iss_rd_addr, rs1_addr, rs2_addr,
      output alu_valid, alu_rd_addr, alu_wdata,
      output lsu_valid, lsu_rd_addr, lsu_rdata, lsu_funct3, lsu_addr_lo,
      input  rs1_busy, rs2_busy, lsu_ready,
      input  rd_addr, rd_wdata, rd_write, err_waw, err_misalign
   );

   modport slave (
      input  iss_valid, iss_long, iss_rd_addr, rs1_addr, rs2_addr,
      input  alu_valid, alu_rd_addr, alu_wdata,
      input  lsu_valid, lsu_rd_addr, lsu_rdata, lsu_funct3, lsu_addr_lo,
      output rs1_busy, rs2_busy, lsu_ready,
      output rd_addr, rd_wdata, rd_write, err_waw, err_misalign
   );

endinterface

// File: rtl/corevx_load_extend.sv
// Combinational load data extraction: selects byte/halfword lane and sign/zero extends.
// Unknown funct3 codes behave as LW; misaligned accesses use the truncated offset.
module corevx_load_extend
   import corevx_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] data_o,
   output logic            misalign_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
   assign half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

   always_comb begin
      data_o     = rdata_i;
      misalign_o = 1'b0;
      case (funct3_i)
         LOAD_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
         LOAD_LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
         LOAD_LH: begin
            data_o     = {{(XLEN-16){half_v[15]}}, half_v};
            misalign_o = addr_lo_i[0];
         end
         LOAD_LHU: begin
            data_o     = {{(XLEN-16){1'b0}}, half_v};
            misalign_o = addr_lo_i[0];
         end
         default: begin
            data_o     = rdata_i;
            misalign_o = |addr_lo_i;
         end
      endcase
   end

endmodule

// File: rtl/corevx_writeback.sv
// Writeback stage: ALU-priority merge of ALU and load results into a registered
// register-file write port, plus the pending-long-write scoreboard for decode.
module corevx_writeback
   import corevx_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   corevx_writeback_if.slave  wb
);

   logic            lsu_acc;
   logic [XLEN-1:0] ld_data;
   logic            ld_mis;

   logic            rd_write_q, rd_write_d;
   reg_addr_t       rd_addr_q, rd_addr_d;
   logic [XLEN-1:0] rd_wdata_q, rd_wdata_d;
   logic [NREGS-1:0] pending_q, pending_d;
   logic [NREGS-1:0] set_vec, clr_vec;
   logic            err_waw_q, err_waw_d;
   logic            err_mis_q, err_mis_d;

   assign wb.lsu_ready = !wb.alu_valid;
   assign lsu_acc      = wb.lsu_valid && !wb.alu_valid;

   corevx_load_extend u_load_extend (
      .funct3_i   (wb.lsu_funct3),
      .addr_lo_i  (wb.lsu_addr_lo),
      .rdata_i    (wb.lsu_rdata),
      .data_o     (ld_data),
      .misalign_o (ld_mis)
   );

   // Write to x0 still updates the address/data register but never strobes the write.
   always_comb begin
      rd_write_d = 1'b0;
      rd_addr_d  = rd_addr_q;
      rd_wdata_d = rd_wdata_q;
      if (wb.alu_valid) begin
         rd_write_d = (wb.alu_rd_addr != '0);
         rd_addr_d  = wb.alu_rd_addr;
         rd_wdata_d = wb.alu_wdata;
      end else if (lsu_acc) begin
         rd_write_d = (wb.lsu_rd_addr != '0);
         rd_addr_d  = wb.lsu_rd_addr;
         rd_wdata_d = ld_data;
      end
   end

   // Set is applied after clear so a same-cycle reissue keeps the bit pending.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (wb.iss_valid && wb.iss_long) set_vec[wb.iss_rd_addr] = 1'b1;
      if (lsu_acc)                     clr_vec[wb.lsu_rd_addr] = 1'b1;
      pending_d    = (pending_q & ~clr_vec) | set_vec;
      pending_d[0] = 1'b0;
      err_waw_d    = err_waw_q |
                     (wb.iss_valid && wb.iss_long && (wb.iss_rd_addr != '0) &&
                      pending_q[wb.iss_rd_addr] && !clr_vec[wb.iss_rd_addr]);
      err_mis_d    = err_mis_q | (lsu_acc && ld_mis);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_write_q <= 1'b0;
         rd_addr_q  <= '0;
         rd_wdata_q <= '0;
         pending_q  <= '0;
         err_waw_q  <= 1'b0;
         err_mis_q  <= 1'b0;
      end else begin
         rd_write_q <= rd_write_d;
         rd_addr_q  <= rd_addr_d;
         rd_wdata_q <= rd_wdata_d;
         pending_q  <= pending_d;
         err_waw_q  <= err_waw_d;
         err_mis_q  <= err_mis_d;
      end
   end

   assign wb.rs1_busy     = pending_q[wb.rs1_addr];
   assign wb.rs2_busy     = pending_q[wb.rs2_addr];
   assign wb.rd_write     = rd_write_q;
   assign wb.rd_addr      = rd_addr_q;
   assign wb.rd_wdata     = rd_wdata_q;
   assign wb.err_waw      = err_waw_q;
   assign wb.err_misalign = err_mis_q;

endmodule

// File: tb/tb_corevx_writeback.sv
// Self-checking bench for corevx_writeback: directed scenarios plus a randomized
// run against a behavioural model of the write port, scoreboard and sticky errors.
module tb_corevx_writeback;
   import corevx_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   corevx_writeback_if bus ();

   corevx_writeback dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_load(input int f3, input int lo, input logic [31:0] w);
      longint v;
      case (f3)
         0, 4: begin
            v = longint'((w >> (8 * lo)) & 32'hFF);
            if (f3 == 0 && v >= 128) v = v - 256;
         end
         1, 5: begin
            v = longint'((w >> (16 * (lo / 2))) & 32'hFFFF);
            if (f3 == 1 && v >= 32768) v = v - 65536;
         end
         default: v = longint'(w);
      endcase
      return v[31:0];
   endfunction

   function automatic bit ref_mis(input int f3, input int lo);
      case (f3)
         0, 4:    return 1'b0;
         1, 5:    return (lo % 2) == 1;
         default: return lo != 0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.iss_valid   = 1'b0;
      bus.iss_long    = 1'b0;
      bus.iss_rd_addr = '0;
      bus.alu_valid   = 1'b0;
      bus.alu_rd_addr = '0;
      bus.alu_wdata   = '0;
      bus.lsu_valid   = 1'b0;
      bus.lsu_rd_addr = '0;
      bus.lsu_rdata   = '0;
      bus.lsu_funct3  = 3'd2;
      bus.lsu_addr_lo = 2'd0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      bus.alu_valid   = 1'b1;
      bus.alu_rd_addr = 5'd5;
      bus.alu_wdata   = 32'h1234;
      bus.rs1_addr    = 5'd5;
      bus.rs2_addr    = 5'd7;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.rd_write !== 1'b0 || bus.rd_addr !== 5'd0 || bus.rd_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got write=%b addr=%0d data=%h exp 0/0/0",
                     bus.rd_write, bus.rd_addr, bus.rd_wdata);
         end
         checks++;
         if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 ||
             bus.err_waw !== 1'b0 || bus.err_misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b%b waw=%b mis=%b exp 0000",
                     bus.rs1_busy, bus.rs2_busy, bus.err_waw, bus.err_misalign);
         end
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.rd_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_early: got write=%b exp 0", bus.rd_write);
      end
      tick();
      checks++;
      if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd5 || bus.rd_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL reset_first_write: got write=%b addr=%0d data=%h exp 1/5/00001234",
                  bus.rd_write, bus.rd_addr, bus.rd_wdata);
      end
   endtask

   task automatic test_alu();
      idle();
      bus.alu_valid   = 1'b1;
      bus.alu_rd_addr = 5'd5;
      bus.alu_wdata   = 32'hCAFE_0001;
      tick();
      checks++;
      if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd5 || bus.rd_wdata !== 32'hCAFE_0001) begin
         errors++;
         $display("FAIL alu_write: got write=%b addr=%0d data=%h exp 1/5/cafe0001",
                  bus.rd_write, bus.rd_addr, bus.rd_wdata);
      end
      idle();
      tick();
      checks++;
      if (bus.rd_write !== 1'b0 || bus.rd_addr !== 5'd5 || bus.rd_wdata !== 32'hCAFE_0001) begin
         errors++;
         $display("FAIL alu_hold: got write=%b addr=%0d data=%h exp 0/5/cafe0001",
                  bus.rd_write, bus.rd_addr, bus.rd_wdata);
      end
      bus.alu_valid   = 1'b1;
      bus.alu_rd_addr = 5'd0;
      bus.alu_wdata   = 32'h1234;
      tick();
      checks++;
      if (bus.rd_write !== 1'b0) begin
         errors++;
         $display("FAIL alu_x0: got write=%b exp 0", bus.rd_write);
      end
   endtask

   task automatic test_arbitration();
      idle();
      bus.alu_valid   = 1'b1;
      bus.alu_rd_addr = 5'd3;
      bus.alu_wdata   = 32'hAAAA_5555;
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd_addr = 5'd9;
      bus.lsu_rdata   = 32'h0BAD_F00D;
      bus.lsu_funct3  = 3'd2;
      #1;
      checks++;
      if (bus.lsu_ready !== 1'b0) begin
         errors++;
         $display("FAIL arb_ready_low: got %b exp 0", bus.lsu_ready);
      end
      tick();
      checks++;
      if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd3 || bus.rd_wdata !== 32'hAAAA_5555) begin
         errors++;
         $display("FAIL arb_alu_wins: got write=%b addr=%0d data=%h exp 1/3/aaaa5555",
                  bus.rd_write, bus.rd_addr, bus.rd_wdata);
      end
      bus.alu_valid = 1'b0;
      #1;
      checks++;
      if (bus.lsu_ready !== 1'b1) begin
         errors++;
         $display("FAIL arb_ready_high: got %b exp 1", bus.lsu_ready);
      end
      tick();
      checks++;
      if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd9 || bus.rd_wdata !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL arb_load_after_stall: got write=%b addr=%0d data=%h exp 1/9/0badf00d",
                  bus.rd_write, bus.rd_addr, bus.rd_wdata);
      end
      idle();
      tick();
   endtask

   task automatic test_load_extract();
      int          f3s [5] = '{0, 4, 1, 5, 2};
      int          los [5] = '{3, 3, 2, 0, 0};
      logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_7F01, 32'h80FF_7F01};
      for (int i = 0; i < 5; i++) begin
         idle();
         bus.lsu_valid   = 1'b1;
         bus.lsu_rd_addr = 5'(10 + i);
         bus.lsu_rdata   = 32'h80FF_7F01;
         bus.lsu_funct3  = 3'(f3s[i]);
         bus.lsu_addr_lo = 2'(los[i]);
         tick();
         checks++;
         if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'(10 + i) || bus.rd_wdata !== exps[i]) begin
            errors++;
            $display("FAIL load_extract f3=%0d lo=%0d: got write=%b addr=%0d data=%h exp 1/%0d/%h",
                     f3s[i], los[i], bus.rd_write, bus.rd_addr, bus.rd_wdata, 10 + i, exps[i]);
         end
      end
      idle();
      tick();
      checks++;
      if (bus.err_misalign !== 1'b0) begin
         errors++;
         $display("FAIL load_aligned_no_err: got %b exp 0", bus.err_misalign);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      bus.iss_valid   = 1'b1;
      bus.iss_long    = 1'b1;
      bus.iss_rd_addr = 5'd7;
      bus.rs1_addr    = 5'd7;
      bus.rs2_addr    = 5'd8;
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b0) begin
         errors++;
         $display("FAIL sb_not_yet_busy: got %b exp 0", bus.rs1_busy);
      end
      tick();
      bus.iss_valid = 1'b0;
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b0) begin
         errors++;
         $display("FAIL sb_busy_set: got rs1=%b rs2=%b exp 1/0", bus.rs1_busy, bus.rs2_busy);
      end
      bus.iss_valid   = 1'b1;
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd_addr = 5'd7;
      bus.lsu_rdata   = 32'h1357_9BDF;
      bus.lsu_funct3  = 3'd2;
      tick();
      checks++;
      if (bus.rs1_busy !== 1'b1 || bus.err_waw !== 1'b0) begin
         errors++;
         $display("FAIL sb_set_wins: got busy=%b waw=%b exp 1/0", bus.rs1_busy, bus.err_waw);
      end
      checks++;
      if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd7 || bus.rd_wdata !== 32'h1357_9BDF) begin
         errors++;
         $display("FAIL sb_load_write: got write=%b addr=%0d data=%h exp 1/7/13579bdf",
                  bus.rd_write, bus.rd_addr, bus.rd_wdata);
      end
      bus.lsu_valid = 1'b0;
      tick();
      checks++;
      if (bus.err_waw !== 1'b1) begin
         errors++;
         $display("FAIL sb_waw_set: got %b exp 1", bus.err_waw);
      end
      bus.iss_valid   = 1'b0;
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd_addr = 5'd7;
      tick();
      bus.lsu_valid = 1'b0;
      bus.iss_valid = 1'b1;
      bus.iss_rd_addr = 5'd0;
      bus.rs2_addr  = 5'd0;
      tick();
      bus.iss_valid = 1'b0;
      checks++;
      if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.err_waw !== 1'b1) begin
         errors++;
         $display("FAIL sb_clear_x0_sticky: got busy7=%b busy0=%b waw=%b exp 0/0/1",
                  bus.rs1_busy, bus.rs2_busy, bus.err_waw);
      end
   endtask

   task automatic test_misalign();
      idle();
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd_addr = 5'd20;
      bus.lsu_rdata   = 32'h80FF_7F01;
      bus.lsu_funct3  = 3'd1;
      bus.lsu_addr_lo = 2'd1;
      tick();
      checks++;
      if (bus.err_misalign !== 1'b1 || bus.rd_write !== 1'b1 ||
          bus.rd_addr !== 5'd20 || bus.rd_wdata !== 32'h0000_7F01) begin
         errors++;
         $display("FAIL misalign_lh: got mis=%b write=%b addr=%0d data=%h exp 1/1/20/00007f01",
                  bus.err_misalign, bus.rd_write, bus.rd_addr, bus.rd_wdata);
      end
      bus.lsu_funct3  = 3'd0;
      bus.lsu_addr_lo = 2'd0;
      tick();
      checks++;
      if (bus.err_misalign !== 1'b1) begin
         errors++;
         $display("FAIL misalign_sticky: got %b exp 1", bus.err_misalign);
      end
      idle();
      tick();
   endtask

   task automatic test_reset_mid_stall();
      idle();
      bus.iss_valid   = 1'b1;
      bus.iss_long    = 1'b1;
      bus.iss_rd_addr = 5'd12;
      bus.rs1_addr    = 5'd12;
      tick();
      idle();
      bus.alu_valid   = 1'b1;
      bus.alu_rd_addr = 5'd4;
      bus.alu_wdata   = 32'h4444_4444;
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd_addr = 5'd12;
      bus.lsu_rdata   = 32'h1212_1212;
      tick();
      checks++;
      if (bus.rd_write !== 1'b1 || bus.rs1_busy !== 1'b1 ||
          bus.err_waw !== 1'b1 || bus.err_misalign !== 1'b1) begin
         errors++;
         $display("FAIL stall_pre_reset: got write=%b busy=%b waw=%b mis=%b exp 1111",
                  bus.rd_write, bus.rs1_busy, bus.err_waw, bus.err_misalign);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.rd_write !== 1'b0 || bus.rd_addr !== 5'd0 || bus.rd_wdata !== 32'd0 ||
          bus.rs1_busy !== 1'b0 || bus.err_waw !== 1'b0 || bus.err_misalign !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got write=%b addr=%0d data=%h busy=%b waw=%b mis=%b exp all 0",
                  bus.rd_write, bus.rd_addr, bus.rd_wdata, bus.rs1_busy, bus.err_waw,
                  bus.err_misalign);
      end
      idle();
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.rd_write !== 1'b0 || bus.rs1_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_drops_load: got write=%b busy=%b exp 0/0", bus.rd_write, bus.rs1_busy);
      end
   endtask

   task automatic test_random();
      bit          pend[NREGS];
      bit          m_waw;
      bit          m_mis;
      bit          stalled;
      bit          acc;
      bit          exp_w;
      int          exp_a;
      logic [31:0] exp_d;
      int          irs;
      for (int r = 0; r < NREGS; r++) pend[r] = 1'b0;
      m_waw   = 1'b0;
      m_mis   = 1'b0;
      stalled = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!stalled) begin
            bus.lsu_valid   = 1'($urandom_range(1));
            bus.lsu_rd_addr = 5'($urandom_range(7));
            bus.lsu_funct3  = 3'($urandom_range(7));
            bus.lsu_addr_lo = 2'($urandom_range(3));
            bus.lsu_rdata   = $urandom;
         end
         bus.alu_valid   = ($urandom_range(2) == 0);
         bus.alu_rd_addr = 5'($urandom_range(7));
         bus.alu_wdata   = $urandom;
         bus.iss_valid   = 1'($urandom_range(1));
         bus.iss_long    = 1'($urandom_range(1));
         bus.iss_rd_addr = 5'($urandom_range(7));
         bus.rs1_addr    = 5'($urandom_range(7));
         bus.rs2_addr    = 5'($urandom_range(7));
         #1;
         checks++;
         if (bus.lsu_ready !== !bus.alu_valid || bus.rs1_busy !== pend[int'(bus.rs1_addr)] ||
             bus.rs2_busy !== pend[int'(bus.rs2_addr)]) begin
            errors++;
            $display("FAIL rand_comb c=%0d: got ready=%b busy=%b%b exp %b %b%b", c,
                     bus.lsu_ready, bus.rs1_busy, bus.rs2_busy, !bus.alu_valid,
                     pend[int'(bus.rs1_addr)], pend[int'(bus.rs2_addr)]);
         end
         acc   = bus.lsu_valid && !bus.alu_valid;
         exp_w = 1'b0;
         exp_a = 0;
         exp_d = '0;
         if (bus.alu_valid) begin
            exp_a = int'(bus.alu_rd_addr);
            exp_d = bus.alu_wdata;
            exp_w = exp_a != 0;
         end else if (acc) begin
            exp_a = int'(bus.lsu_rd_addr);
            exp_d = ref_load(int'(bus.lsu_funct3), int'(bus.lsu_addr_lo), bus.lsu_rdata);
            exp_w = exp_a != 0;
            if (ref_mis(int'(bus.lsu_funct3), int'(bus.lsu_addr_lo))) m_mis = 1'b1;
         end
         irs = int'(bus.iss_rd_addr);
         if (bus.iss_valid && bus.iss_long && irs != 0 && pend[irs] &&
             !(acc && int'(bus.lsu_rd_addr) == irs)) m_waw = 1'b1;
         if (acc) pend[int'(bus.lsu_rd_addr)] = 1'b0;
         if (bus.iss_valid && bus.iss_long && irs != 0) pend[irs] = 1'b1;
         stalled = bus.lsu_valid && bus.alu_valid;
         tick();
         checks++;
         if (bus.rd_write !== exp_w || (exp_w && (bus.rd_addr !== 5'(exp_a) || bus.rd_wdata !== exp_d))) begin
            errors++;
            $display("FAIL rand_write c=%0d: got write=%b addr=%0d data=%h exp %b/%0d/%h", c,
                     bus.rd_write, bus.rd_addr, bus.rd_wdata, exp_w, exp_a, exp_d);
         end
         checks++;
         if (bus.err_waw !== m_waw || bus.err_misalign !== m_mis) begin
            errors++;
            $display("FAIL rand_err c=%0d: got waw=%b mis=%b exp %b/%b", c,
                     bus.err_waw, bus.err_misalign, m_waw, m_mis);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.rs1_addr = '0;
      bus.rs2_addr = '0;
      idle();
      test_reset();
      test_alu();
      test_arbitration();
      test_load_extract();
      test_scoreboard();
      test_misalign();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/corevx_writeback.md
Name: corevx_writeback

Overview:
- Writeback stage directly upstream of the core register file; drives its rd_addr / rd_wdata / rd_write write port.
- Merges two result sources:
  - single-cycle ALU results;
  - long-latency load results, with byte/halfword extraction and sign/zero extension.
- Holds a pending-write scoreboard for long ops so decode can detect RAW/WAW hazards.
- Exposes the registered write as a bypass source.

Parameters:
- XLEN, 32, data width of results and register file.
- NREGS, 32, number of architectural registers; address width is $clog2(NREGS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- iss_valid  in  1  decode issues an instruction this cycle.
- iss_long  in  1  issued instruction writes back via the load path.
- iss_rd_addr  in  5  destination of the issued instruction.
- rs1_addr  in  5  decode source 1 address, for scoreboard query.
- rs2_addr  in  5  decode source 2 address, for scoreboard query.
- rs1_busy  out  1  source 1 has a pending long write (combinational).
- rs2_busy  out  1  source 2 has a pending long write (combinational).
- alu_valid  in  1  ALU result present; always accepted.
- alu_rd_addr  in  5  ALU destination.
- alu_wdata  in  XLEN  ALU result.
- lsu_valid  in  1  load result present.
- lsu_ready  out  1  load result accepted this cycle.
- lsu_rd_addr  in  5  load destination.
- lsu_rdata  in  XLEN  raw aligned memory word.
- lsu_funct3  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- lsu_addr_lo  in  2  byte offset of the load.
- rd_addr  out  5  register file write address; also the bypass address.
- rd_wdata  out  XLEN  register file write data; also the bypass data.
- rd_write  out  1  register file write enable; also the bypass valid.
- err_waw  out  1  sticky: long issue to an already-pending register.
- err_misalign  out  1  sticky: misaligned LH/LHU/LW received.

Behaviour:
- Reset (async, rst_n=0):
  - rd_write=0, rd_addr=0, rd_wdata=0;
  - pending[NREGS-1:0]=0;
  - err_waw=0, err_misalign=0.
  - Takes effect mid-operation; any in-flight load result is dropped.
- Arbitration: ALU has fixed priority.
  - lsu_ready = !alu_valid (combinational).
  - A load is accepted when lsu_valid && lsu_ready.
  - Load source must hold lsu_* stable while lsu_valid && !lsu_ready.
- Output register, 1-cycle latency:
  - alu_valid → next edge: rd_write=1, rd_addr=alu_rd_addr, rd_wdata=alu_wdata.
  - Else load accepted → rd_write=1, rd_addr=lsu_rd_addr, rd_wdata=extracted load data.
  - Else rd_write=0; rd_addr and rd_wdata hold their values.
  - Destination x0: rd_write is forced 0 (the register file also guards this).
- Load extraction:
  - LB/LBU: byte lsu_rdata[8*lsu_addr_lo +: 8], sign-extended / zero-extended.
  - LH/LHU: halfword lsu_rdata[16*lsu_addr_lo[1] +: 16], sign-extended / zero-extended.
  - LW: full word.
  - funct3 3, 6, 7: treated as LW.
  - Misaligned (LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0): write still performed using the truncated offset; err_misalign set.
- Scoreboard:
  - Set: pending[iss_rd_addr] on iss_valid && iss_long && iss_rd_addr≠0.
  - Clear: pending[lsu_rd_addr] on accepted load.
  - Set and clear of the same register in one cycle: set wins (bit stays 1).
  - Clear of a non-pending register: no effect, no error.
  - pending[0] is always 0.
  - rsN_busy = pending[rsN_addr], from the current register state; a clear in the same cycle is not reflected until the next cycle.
- err_waw: set when a long issue targets a register whose bit is 1 and not being cleared this cycle. Sticky until reset.
- Bypass: for the one cycle between rd_write assertion and the register file update, decode forwards rd_wdata when rd_write && rd_addr==source address.

Decomposition:
- Shared package corevx_pkg holds:
  - load funct3 constants LOAD_LB/LH/LW/LBU/LHU;
  - XLEN;
  - register address width.
- One natural sub-module: corevx_load_extend, combinational (funct3, addr_lo, rdata → data, misalign).
- Scoreboard stays inline.

Test Plan:
- Reset with alu_valid=1 held → rd_write=0 and pending=0 while rst_n=0; first write appears 1 cycle after release.
- alu_valid, rd=5, data 0x1234 → next cycle rd_write=1, rd_addr=5, rd_wdata=0x1234. Repeat with rd=0 → rd_write=0.
- lsu_valid and alu_valid together → lsu_ready=0 and ALU written. Next cycle, with alu_valid=0, the load is accepted and written; lsu data unchanged while stalled.
- lsu_rdata=0x80FF7F01 with each load type:
  - LB, addr_lo=3 → 0xFFFFFF80;
  - LBU, addr_lo=3 → 0x00000080;
  - LH, addr_lo=2 → 0xFFFF80FF;
  - LHU, addr_lo=0 → 0x00007F01;
  - LW → 0x80FF7F01.
- Issue long to x7 → rs1_busy=1 for rs1_addr=7 from the next cycle. Load to x7 accepted in the same cycle as a new long issue to x7 → bit stays 1, err_waw=0. A further long issue to x7 → err_waw=1.
- LH with addr_lo=1 → err_misalign=1 (sticky) and write performed. Assert rst_n mid-stall → all outputs return to reset values asynchronously.
